// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back arbiter: request payload and
// output source selector.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_BYPASS
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO of write-back requests; every slot and its
// valid bit are exposed so the arbiter can search pending destinations.
import wb_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count,
  output wb_req_t                head,
  output wb_req_t [DEPTH-1:0]    entries,
  output logic [DEPTH-1:0]       entry_valid
);

  wb_req_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  // NOTE: storage carries no reset; entry_valid and count decide what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        wr_ptr              <= wr_ptr + PTR_W'(1);
        entry_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr              <= rd_ptr + PTR_W'(1);
        entry_valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign entries = mem;

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges ALU and long-latency results onto the single register-file write port.
// Optional pending-write lookup is built when WB_PENDING_CHECK_EN is defined.
import wb_pkg::*;

module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [4:0]                   alu_rd,
  input  logic [31:0]                  alu_data,
  input  logic                         lu_valid,
  output logic                         lu_ready,
  input  logic [4:0]                   lu_rd,
  input  logic [31:0]                  lu_data,
  output logic                         RegWrite,
  output logic [4:0]                   rd,
  output logic [31:0]                  WriteData,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  input  logic [4:0]                   chk_rs,
  input  logic [4:0]                   chk_rt,
  output logic                         pend_rs,
  output logic                         pend_rt
);

  localparam int ST_W = $clog2(STARVE_LIMIT + 1);

  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                forced;
  wb_req_t             head;
  wb_req_t             sel;
  wb_req_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]    entry_valid;
  logic [ST_W-1:0]     starve_cnt;
  wb_src_e             src;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   ('{rd: lu_rd, data: lu_data}),
    .pop         (pop),
    .full        (full),
    .empty       (empty),
    .count       (fifo_count),
    .head        (head),
    .entries     (entries),
    .entry_valid (entry_valid)
  );

  assign forced    = (starve_cnt == ST_W'(STARVE_LIMIT)) && !empty;
  assign alu_ready = !forced;
  assign lu_ready  = !full;

  // NOTE: defaults first so no path through the block leaves a signal unassigned.
  always_comb begin
    src = SRC_NONE;
    sel = head;
    if (forced) begin
      src = SRC_FIFO;
    end else if (alu_valid) begin
      src = SRC_ALU;
      sel = '{rd: alu_rd, data: alu_data};
    end else if (!empty) begin
      src = SRC_FIFO;
    end else if (lu_valid) begin
      src = SRC_BYPASS;
      sel = '{rd: lu_rd, data: lu_data};
    end
  end

  // A bypassed LU result goes straight to the output, never into the FIFO.
  assign push = lu_valid && !full && (src != SRC_BYPASS);
  assign pop  = (src == SRC_FIFO);

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      rd        <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= (src != SRC_NONE) && (sel.rd != '0);
      if (src != SRC_NONE) begin
        rd        <= sel.rd;
        WriteData <= sel.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || empty || pop) begin
      starve_cnt <= '0;
    end else if (src == SRC_ALU && starve_cnt != ST_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + ST_W'(1);
    end
  end

`ifdef WB_PENDING_CHECK_EN
  always_comb begin
    pend_rs = RegWrite && (rd == chk_rs);
    pend_rt = RegWrite && (rd == chk_rt);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entries[i].rd == chk_rs) pend_rs = 1'b1;
      if (entry_valid[i] && entries[i].rd == chk_rt) pend_rt = 1'b1;
    end
    // $zero is never a real hazard.
    if (chk_rs == '0) pend_rs = 1'b0;
    if (chk_rt == '0) pend_rt = 1'b0;
  end
`else
  logic unused_pend;
  assign unused_pend = ^{chk_rs, chk_rt, entries, entry_valid};
  assign pend_rs     = 1'b0;
  assign pend_rt     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: directed vectors push expected writes,
// a monitor pops and compares each RegWrite=1 cycle.
module tb_wb_write_arbiter;
  import wb_pkg::*;

`ifdef WB_PENDING_CHECK_EN
  localparam logic PEND_EN = 1'b1;
`else
  localparam logic PEND_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, lu_valid, lu_ready;
  logic [4:0]  alu_rd, lu_rd, rd, chk_rs, chk_rt;
  logic [31:0] alu_data, lu_data, WriteData;
  logic        RegWrite, pend_rs, pend_rt;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;
  wb_req_t exp_q[$];

  wb_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .RegWrite   (RegWrite),
    .rd         (rd),
    .WriteData  (WriteData),
    .fifo_count (fifo_count),
    .chk_rs     (chk_rs),
    .chk_rt     (chk_rt),
    .pend_rs    (pend_rs),
    .pend_rt    (pend_rt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check readies and occupancy, queue the write
  // this cycle is expected to produce, then advance to just past the edge.
  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     input logic ear, input logic elr, input int ecnt,
                     input logic ewe, input logic [4:0] erd, input logic [31:0] edat);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lu_valid  = lv; lu_rd  = lrd; lu_data  = ldat;
    #1;
    check("alu_ready", {31'b0, alu_ready}, {31'b0, ear});
    check("lu_ready", {31'b0, lu_ready}, {31'b0, elr});
    check("fifo_count", {29'b0, fifo_count}, ecnt);
    if (ewe) exp_q.push_back('{rd: erd, data: edat});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int ecnt, input logic ewe, input logic [4:0] erd, input logic [31:0] edat);
    cyc(0, 0, 0, 0, 0, 0, 1, ecnt < 4, ecnt, ewe, erd, edat);
  endtask

  // Monitor: every output write must match the next scoreboard entry.
  initial begin
    wb_req_t e;
    forever begin
      @(posedge clk);
      #3;
      if (RegWrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {27'b0, rd}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wb_rd", {27'b0, rd}, {27'b0, e.rd});
          check("wb_data", WriteData, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lu_valid  = 0; lu_rd  = 0; lu_data  = 0;
    chk_rs = 0; chk_rt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_regwrite", {31'b0, RegWrite}, 0);
    check("rst_rd", {27'b0, rd}, 0);
    check("rst_wdata", WriteData, 0);
    check("rst_count", {29'b0, fifo_count}, 0);
    check("rst_pend_rs", {31'b0, pend_rs}, 0);
    reset = 1'b0;

    // ALU alone, one-cycle latency, then hold on an idle cycle
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 0, 1, 5, 32'hDEADBEEF);
    check("alu_lat_we", {31'b0, RegWrite}, 1);
    check("alu_lat_rd", {27'b0, rd}, 5);
    idle(0, 0, 0, 0);
    check("idle_we", {31'b0, RegWrite}, 0);
    check("idle_rd_hold", {27'b0, rd}, 5);
    check("idle_wd_hold", WriteData, 32'hDEADBEEF);

    // LU bypass with empty FIFO
    cyc(0, 0, 0, 1, 9, 32'h12, 1, 1, 0, 1, 9, 32'h12);
    check("byp_we", {31'b0, RegWrite}, 1);
    check("byp_rd", {27'b0, rd}, 9);
    check("byp_count", {29'b0, fifo_count}, 0);

    // Starvation: LU rd=7 queued behind a continuously valid ALU
    cyc(1, 10, 32'hA0, 1, 7, 32'h70, 1, 1, 0, 1, 10, 32'hA0);
    cyc(1, 11, 32'hA1, 0, 0, 0,      1, 1, 1, 1, 11, 32'hA1);
    cyc(1, 12, 32'hA2, 0, 0, 0,      1, 1, 1, 1, 12, 32'hA2);
    cyc(1, 13, 32'hA3, 0, 0, 0,      1, 1, 1, 1, 13, 32'hA3);
    cyc(1, 14, 32'hA4, 0, 0, 0,      0, 1, 1, 1, 7,  32'h70);
    check("starve_rd", {27'b0, rd}, 7);
    cyc(1, 14, 32'hA4, 0, 0, 0,      1, 1, 0, 1, 14, 32'hA4);
    idle(0, 0, 0, 0);

    // Full FIFO: four LU enqueues while the ALU is busy, then in-order drain
    cyc(1, 16, 32'h160, 1, 20, 32'h200, 1, 1, 0, 1, 16, 32'h160);
    cyc(1, 17, 32'h170, 1, 21, 32'h210, 1, 1, 1, 1, 17, 32'h170);
    cyc(1, 18, 32'h180, 1, 22, 32'h220, 1, 1, 2, 1, 18, 32'h180);
    cyc(1, 19, 32'h190, 1, 23, 32'h230, 1, 1, 3, 1, 19, 32'h190);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 20, 32'h200);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 3, 1, 21, 32'h210);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 22, 32'h220);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 23, 32'h230);
    idle(0, 0, 0, 0);

    // $zero write is consumed but not enabled
    cyc(1, 0, 32'h55, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    check("zero_we", {31'b0, RegWrite}, 0);
    check("zero_rd", {27'b0, rd}, 0);
    check("zero_wd", WriteData, 32'h55);

    // Pending check: LU rd=3 in the FIFO, ALU rd=4 in the output stage
    cyc(1, 4, 32'h44, 1, 3, 32'h33, 1, 1, 0, 1, 4, 32'h44);
    alu_valid = 0; lu_valid = 0;
    chk_rs = 3; chk_rt = 0;
    #1;
    check("pend_rs_fifo", {31'b0, pend_rs}, {31'b0, PEND_EN});
    check("pend_rt_zero", {31'b0, pend_rt}, 0);
    chk_rs = 4; chk_rt = 6;
    #1;
    check("pend_rs_out", {31'b0, pend_rs}, {31'b0, PEND_EN});
    check("pend_rt_miss", {31'b0, pend_rt}, 0);
    chk_rs = 0; chk_rt = 0;
    @(posedge clk);
    #1;
    idle(0, 1, 3, 32'h33);
    check("pend_drain_rd", {27'b0, rd}, 3);
    idle(0, 0, 0, 0);

    // Reset mid-stream with three entries queued
    cyc(1, 1, 32'h1, 1, 26, 32'h260, 1, 1, 0, 1, 1, 32'h1);
    cyc(1, 2, 32'h2, 1, 27, 32'h270, 1, 1, 1, 1, 2, 32'h2);
    cyc(1, 8, 32'h8, 1, 28, 32'h280, 1, 1, 2, 1, 8, 32'h8);
    alu_valid = 0; lu_valid = 0;
    reset = 1'b1;
    check("pre_rst_count", {29'b0, fifo_count}, 3);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_we", {31'b0, RegWrite}, 0);
    check("mid_rst_count", {29'b0, fifo_count}, 0);
    check("mid_rst_lu_ready", {31'b0, lu_ready}, 1);
    check("mid_rst_wd", WriteData, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 0, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
